// File: rtl/alu_exec_stage_if.sv
// rtl/alu_exec_stage_if.sv - request/response bundle of the execute stage
`timescale 1ns/1ps

// Request side: in_valid/in_ready/op/a/b.
// Response side: out_valid/out_ready plus the result word(s) and flags.
interface alu_exec_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        carry;
  logic        zero;
  logic        sign;
  logic        overflow;

  // Issuer / result consumer
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, result_hi, carry, zero, sign, overflow
  );

  // Execute stage
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, result_hi, carry, zero, sign, overflow
  );
endinterface

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - execute stage around one shared 32-bit hybrid adder
`timescale 1ns/1ps

// Carry-select adder: four 8-bit ripple blocks, each computed for both
// carry-in values, with the block carry choosing between them.
module hybrid_adder (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);
  logic [4:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < 4; g++) begin : g_blk
    logic [8:0] w_s0;
    logic [8:0] w_s1;
    assign w_s0               = {1'b0, i_a[g*8 +: 8]} + {1'b0, i_b[g*8 +: 8]};
    assign w_s1               = w_s0 + 9'd1;
    assign o_sum[g*8 +: 8]    = w_c[g] ? w_s1[7:0] : w_s0[7:0];
    assign w_c[g+1]           = w_c[g] ? w_s1[8]   : w_s0[8];
  end

  assign o_cout = w_c[4];
endmodule

// ADD/SUB/NEG finish in one cycle; MULU iterates 32 shift-add steps on the
// same adder. Results and flags are registered and held until consumed.
module alu_exec_stage #(
  parameter bit MUL_EN = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  alu_exec_stage_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MULU = 2'b10;
  localparam logic [1:0] OP_NEG  = 2'b11;

  state_t      r_state;
  logic [31:0] r_a;
  logic [31:0] r_acc_hi;
  logic [31:0] r_acc_lo;
  logic [4:0]  r_cnt;
  logic        r_out_valid;
  logic [31:0] r_result;
  logic [31:0] r_result_hi;
  logic        r_carry;
  logic        r_zero;
  logic        r_sign;
  logic        r_overflow;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_is_mul;
  logic [31:0] w_add_a;
  logic [31:0] w_add_b;
  logic        w_cin;
  logic [31:0] w_sum;
  logic        w_cout;
  logic        w_ovf;
  logic [31:0] w_mul_hi;
  logic [31:0] w_mul_lo;

  // A finished result can be swapped for a new request in the same cycle it is taken.
  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_is_mul   = (bus.op == OP_MULU) && MUL_EN;

  // Adder operand mux: accumulator step while multiplying, otherwise the incoming request.
  always_comb begin
    w_add_a = 32'd0;
    w_add_b = 32'd0;
    w_cin   = 1'b0;
    if (r_state == S_MUL) begin
      w_add_a = r_acc_hi;
      w_add_b = r_acc_lo[0] ? r_a : 32'd0;
    end else begin
      case (bus.op)
        OP_ADD: begin
          w_add_a = bus.a;
          w_add_b = bus.b;
        end
        OP_SUB: begin
          w_add_a = bus.a;
          w_add_b = ~bus.b;
          w_cin   = 1'b1;
        end
        OP_NEG: begin
          w_add_b = ~bus.b;
          w_cin   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  hybrid_adder u_adder (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (w_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign w_ovf    = (w_add_a[31] == w_add_b[31]) && (w_sum[31] != w_add_a[31]);
  assign w_mul_hi = {w_cout, w_sum[31:1]};
  assign w_mul_lo = {w_sum[0], r_acc_lo[31:1]};

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= 32'd0;
      r_acc_hi    <= 32'd0;
      r_acc_lo    <= 32'd0;
      r_cnt       <= 5'd0;
      r_out_valid <= 1'b0;
      r_result    <= 32'd0;
      r_result_hi <= 32'd0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_sign      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if ((r_state == S_DONE) && bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
          if (w_accept) begin
            if (w_is_mul) begin
              r_state     <= S_MUL;
              r_a         <= bus.a;
              r_acc_hi    <= 32'd0;
              r_acc_lo    <= bus.b;
              r_cnt       <= 5'd0;
              r_out_valid <= 1'b0;
              r_result    <= 32'd0;
              r_result_hi <= 32'd0;
              r_carry     <= 1'b0;
              r_zero      <= 1'b0;
              r_sign      <= 1'b0;
              r_overflow  <= 1'b0;
            end else if (bus.op == OP_MULU) begin
              // Multiplier disabled: the op retires at once with all-zero outputs.
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_result    <= 32'd0;
              r_result_hi <= 32'd0;
              r_carry     <= 1'b0;
              r_zero      <= 1'b0;
              r_sign      <= 1'b0;
              r_overflow  <= 1'b0;
            end else begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_sum;
              r_result_hi <= 32'd0;
              r_carry     <= w_cout;
              r_zero      <= (w_sum == 32'd0);
              r_sign      <= w_sum[31];
              r_overflow  <= w_ovf;
            end
          end
        end
        S_MUL: begin
          r_acc_hi <= w_mul_hi;
          r_acc_lo <= w_mul_lo;
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_mul_lo;
            r_result_hi <= w_mul_hi;
            r_carry     <= 1'b0;
            r_zero      <= (w_mul_hi == 32'd0) && (w_mul_lo == 32'd0);
            r_sign      <= w_mul_hi[31];
            r_overflow  <= (w_mul_hi != 32'd0);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.result_hi = r_result_hi;
  assign bus.carry     = r_carry;
  assign bus.zero      = r_zero;
  assign bus.sign      = r_sign;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - scoreboard bench for alu_exec_stage
`timescale 1ns/1ps

module tb_alu_exec_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alu_exec_stage_if bus();

  alu_exec_stage #(.MUL_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic        c;
    logic        z;
    logic        s;
    logic        v;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    errors = 0;
  int    checks = 0;

  function automatic exp_t mk(input logic [31:0] r, input logic [31:0] h,
                              input logic c, input logic z, input logic s, input logic v);
    exp_t e;
    e = {r, h, c, z, s, v};
    return e;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every consumed output is compared against the oldest expectation.
  initial begin
    exp_t got;
    exp_t e;
    string nm;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        got = {bus.result, bus.result_hi, bus.carry, bus.zero, bus.sign, bus.overflow};
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got result 0x%0h hi 0x%0h with no expected entry",
                   bus.result, bus.result_hi);
        end else begin
          e  = q.pop_front();
          nm = nq.pop_front();
          chk(nm, got, e);
        end
      end
    end
  end

  // Issue one request; the expectation is queued on the accepting edge.
  task automatic send(input string nm, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input exp_t e);
    logic rdy;
    bit   done;
    done = 1'b0;
    @(posedge clk);
    #1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) begin
        q.push_back(e);
        nq.push_back(nm);
        done = 1'b1;
      end
    end
    #1;
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: got in_ready=0 for 200 cycles expected acceptance", nm);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int busy_bad;
    int stale;
    bit seen;

    bus.in_valid = 1'b0;
    bus.op = 2'b00;
    bus.a = 32'd0;
    bus.b = 32'd0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.out_valid, bus.result, bus.result_hi, bus.carry, bus.zero,
                          bus.sign, bus.overflow}, 72'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", bus.in_ready, 72'd1);

    // ADD wrap to zero, then check single-cycle latency
    send("add_wrap", 2'b00, 32'hFFFF_FFFF, 32'h1, mk(32'h0, 32'h0, 1, 1, 0, 0));
    @(negedge clk);
    chk("add_latency_valid", bus.out_valid, 72'd1);
    send("add_ovf", 2'b00, 32'h7FFF_FFFF, 32'h1, mk(32'h8000_0000, 32'h0, 0, 0, 1, 1));

    // SUB
    send("sub_ovf", 2'b01, 32'h8000_0000, 32'h1, mk(32'h7FFF_FFFF, 32'h0, 1, 0, 0, 1));
    send("sub_borrow", 2'b01, 32'd5, 32'd7, mk(32'hFFFF_FFFE, 32'h0, 0, 0, 1, 0));

    // MULU max x max with exact latency and in_ready low throughout
    send("mulu_max", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
         mk(32'h0000_0001, 32'hFFFF_FFFE, 0, 0, 1, 1));
    lat = 0;
    busy_bad = 0;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (k <= 32 && bus.in_ready !== 1'b0) busy_bad++;
      if (bus.out_valid === 1'b1) begin
        lat = k;
        seen = 1'b1;
      end
    end
    chk("mulu_in_ready_low", busy_bad, 72'd0);
    chk("mulu_latency", lat, 72'd33);

    send("mulu_small", 2'b10, 32'd3, 32'd5, mk(32'd15, 32'h0, 0, 0, 0, 0));
    send("mulu_2pow32", 2'b10, 32'h0001_0000, 32'h0001_0000, mk(32'h0, 32'h1, 0, 0, 0, 1));
    send("mulu_zero", 2'b10, 32'd0, 32'd123, mk(32'h0, 32'h0, 0, 1, 0, 0));

    // NEG
    send("neg_zero", 2'b11, 32'h1234_5678, 32'h0, mk(32'h0, 32'h0, 1, 1, 0, 0));
    send("neg_min", 2'b11, 32'h0, 32'h8000_0000, mk(32'h8000_0000, 32'h0, 0, 0, 1, 1));

    // Backpressure: ADD 3+4 held, then handshake with a simultaneous ADD 1+1
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send("bp_add", 2'b00, 32'd3, 32'd4, mk(32'd7, 32'h0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", bus.out_valid, 72'd1);
      chk("bp_result", bus.result, 72'd7);
      chk("bp_in_ready", bus.in_ready, 72'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bus.op = 2'b00;
    bus.a = 32'd1;
    bus.b = 32'd1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", bus.in_ready, 72'd1);
    @(posedge clk);
    q.push_back(mk(32'd2, 32'h0, 0, 0, 0, 0));
    nq.push_back("bp_next_add");
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_continuous_valid", bus.out_valid, 72'd1);
    chk("bp_next_result", bus.result, 72'd2);
    @(negedge clk);
    chk("bp_valid_drop", bus.out_valid, 72'd0);

    // Reset at MUL iteration 10
    send("mul_abort", 2'b10, 32'd7, 32'd9, mk(32'd63, 32'h0, 0, 0, 0, 0));
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    nq.delete();
    #1;
    chk("abort_outputs", {bus.out_valid, bus.result, bus.result_hi, bus.carry, bus.zero,
                          bus.sign, bus.overflow}, 72'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) stale++;
    end
    chk("abort_no_stale", stale, 72'd0);
    send("post_reset_add", 2'b00, 32'd2, 32'd2, mk(32'd4, 32'h0, 0, 0, 0, 0));
    @(negedge clk);
    chk("post_reset_valid", bus.out_valid, 72'd1);
    chk("post_reset_result", bus.result, 72'd4);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 72'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
